usr_sequencer: RTL and testbench

- Command sequencer that sits directly upstream of univ_shift_register and drives its data and control inputs.
- Accepts one command per valid/ready handshake: a parallel-load value, a shift/rotate op and a step count.
- Issues one LOAD cycle followed by `count` op cycles, then samples the register's Q and returns it as result with a one-cycle done pulse.
- Replaces hand-driven control stimulus at system level.

---
 rtl/usr_pkg.sv | 29 ++
 rtl/usr_sequencer_if.sv | 25 ++
 rtl/univ_shift_register.sv | 37 +++
 rtl/usr_step_counter.sv | 34 +++
 rtl/usr_sequencer.sv | 109 ++++++++++
 tb/tb_usr_sequencer.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared control codes, sequencer states and helpers for the shift-register path
package usr_pkg;

  localparam int USR_WIDTH = 4;

  typedef enum logic [2:0] {
    HOLD     = 3'b000,
    SHR      = 3'b001,
    SHL      = 3'b010,
    LOAD     = 3'b011,
    ROR      = 3'b100,
    ROL      = 3'b101,
    CLR      = 3'b110,
    RESERVED = 3'b111
  } usr_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } usr_state_e;

  // HOLD and LOAD are valid register controls but meaningless as a repeated run op
  function automatic logic usr_legal_op(input logic [2:0] op);
    return (op == SHR) || (op == SHL) || (op == ROR) || (op == ROL) || (op == CLR);
  endfunction

endpackage

// File: rtl/usr_sequencer_if.sv
// rtl/usr_sequencer_if.sv - command and result bundle between a command source and usr_sequencer
interface usr_sequencer_if #(
  parameter int WIDTH = usr_pkg::USR_WIDTH,
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, busy, done, err, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, busy, done, err, result
  );
endinterface

// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - universal shift register with load, shift, rotate and clear
module univ_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (control)
      SHR:     q_d = {1'b0, q_q[WIDTH-1:1]};
      SHL:     q_d = {q_q[WIDTH-2:0], 1'b0};
      LOAD:    q_d = data;
      ROR:     q_d = {q_q[0], q_q[WIDTH-1:1]};
      ROL:     q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      CLR:     q_d = '0;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;
endmodule

// File: rtl/usr_step_counter.sv
// rtl/usr_step_counter.sv - loadable down-counter tracking remaining op steps
module usr_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remaining,
  output logic             last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign remaining = cnt_q;
  assign last      = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/usr_sequencer.sv
// rtl/usr_sequencer.sv - turns load/op/count commands into control cycles for univ_shift_register
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  usr_sequencer_if.slave   cmd,
  output logic [WIDTH-1:0] data,
  output logic [2:0]       control,
  input  logic [WIDTH-1:0] q_in
);
  usr_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       control_q, control_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_remaining;

  // Count is loaded on accept, so the LOAD state already sees the step count
  usr_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .load_val  (cmd.cmd_count),
    .remaining (cnt_remaining),
    .last      (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    control_d = HOLD;
    result_d  = result_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d      = cmd.cmd_op;
          data_d    = cmd.cmd_data;
          control_d = LOAD;
          cnt_load  = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (usr_legal_op(op_q) && (cnt_remaining != '0)) begin
          control_d = op_q;
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_FINISH;
        end
      end
      ST_RUN: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d   = ST_FINISH;
        end else begin
          control_d = op_q;
        end
      end
      ST_FINISH: begin
        result_d = q_in;
        done_d   = 1'b1;
        err_d    = !usr_legal_op(op_q);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= HOLD;
      data_q    <= '0;
      control_q <= HOLD;
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      control_q <= control_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign data          = data_q;
  assign control       = control_q;
  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.busy      = (state_q != ST_IDLE);
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.result    = result_q;
endmodule

// File: tb/tb_usr_sequencer.sv
// tb/tb_usr_sequencer.sv - self-checking bench for usr_sequencer driving univ_shift_register
module tb_usr_sequencer;
  import usr_pkg::*;

  localparam int W  = 4;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data;
  logic [W-1:0] q;
  logic [2:0]   control;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  usr_sequencer_if #(.WIDTH(W), .CNT_W(CW)) intf ();

  usr_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .cmd     (intf),
    .data    (data),
    .control (control),
    .q_in    (q)
  );

  univ_shift_register #(.WIDTH(W)) u_sr (
    .clk     (clk),
    .reset   (reset),
    .control (control),
    .data    (data),
    .Q       (q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input int op);
    return (op == 1) || (op == 2) || (op == 4) || (op == 5) || (op == 6);
  endfunction

  // Reference: value left in the register after the load and `cnt` ops
  function automatic int model(input int op, input int d, input int cnt);
    int v = d;
    int m = 1 << W;
    if (!is_legal(op)) return d;
    for (int i = 0; i < cnt; i++) begin
      case (op)
        1: v = v / 2;
        2: v = (v * 2) % m;
        4: v = v / 2 + (v % 2) * (m / 2);
        5: v = (v * 2) % m + v / (m / 2);
        default: v = 0;
      endcase
    end
    return v;
  endfunction

  // Present a command at a negedge; returns at the negedge where done is seen
  task automatic do_cmd(input int op, input int d, input int cnt, input bit hold);
    int  done_at = -1;
    int  loads = 0;
    int  runs = 0;
    int  busys = 0;
    int  waited = 0;
    int  exp_done;
    bit  legal;
    legal    = is_legal(op);
    exp_done = (legal && cnt > 0) ? cnt + 2 : 2;
    intf.cmd_op    = 3'(op);
    intf.cmd_data  = W'(d);
    intf.cmd_count = CW'(cnt);
    intf.cmd_valid = 1'b1;
    while (!intf.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", 32'(intf.cmd_ready), 1);
    @(posedge clk);
    #1;
    if (!hold) intf.cmd_valid = 1'b0;
    for (int j = 0; j < 40 && done_at < 0; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk("load_data", 32'(data), 32'(d));
        chk("done_single_pulse", 32'(intf.done), 0);
      end
      if (intf.done) begin
        done_at = j;
      end else begin
        if (control == LOAD) loads++;
        else if (control != HOLD) runs++;
        if (intf.busy) busys++;
      end
    end
    intf.cmd_valid = 1'b0;
    chk("done_latency", 32'(done_at), 32'(exp_done));
    chk("result", 32'(intf.result), 32'(model(op, d, cnt)));
    chk("err", 32'(intf.err), 32'(!legal));
    chk("load_cycles", 32'(loads), 1);
    chk("op_cycles", 32'(runs), legal ? 32'(cnt) : 0);
    chk("busy_cycles", 32'(busys), 32'(exp_done));
  endtask

  initial begin
    reset          = 1'b0;
    intf.cmd_valid = 1'b0;
    intf.cmd_op    = '0;
    intf.cmd_data  = '0;
    intf.cmd_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_control", 32'(control), 32'(HOLD));
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(intf.busy), 0);
    chk("rst_done", 32'(intf.done), 0);
    chk("rst_err", 32'(intf.err), 0);
    chk("rst_result", 32'(intf.result), 0);
    chk("rst_ready", 32'(intf.cmd_ready), 1);
    reset = 1'b1;
    @(negedge clk);

    do_cmd(1, 4'b1000, 2, 1'b0);
    do_cmd(5, 4'b1010, 1, 1'b0);
    do_cmd(2, 4'b1111, 3, 1'b0);
    do_cmd(4, 4'b1110, 0, 1'b0);
    do_cmd(7, 4'b0110, 5, 1'b1);

    // Asynchronous reset in the middle of a run abandons the command
    intf.cmd_op    = 3'(SHR);
    intf.cmd_data  = 4'b1111;
    intf.cmd_count = 4'd4;
    intf.cmd_valid = 1'b1;
    @(posedge clk);
    #1 intf.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrun_control", 32'(control), 32'(HOLD));
    chk("midrun_busy", 32'(intf.busy), 0);
    chk("midrun_data", 32'(data), 0);
    chk("midrun_result", 32'(intf.result), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrun_no_done", 32'(intf.done), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    do_cmd(1, 4'b1111, 4, 1'b0);

    do_cmd(6, 4'b1011, 15, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
